instruction_fetch: RTL

- Initiator side of the instruction memory interface.
- Owns the program counter and drives a word-aligned byte address to instruction memory, whose read is combinational.
- Registers the returned instruction together with its PC and hands the pair to decode over a valid/ready handshake.
- Handles branch redirects and squashes, and flags out-of-range or misaligned fetches.

---
 rtl/cpu_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_if.sv | 28 ++
 rtl/instruction_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared types, constants and helpers for the instruction fetch stage.
package cpu_fetch_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned RESET_PC  = 100;
  localparam int unsigned MEM_DEPTH = 256;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  // A PC is fetchable when it is word aligned and inside the memory.
  function automatic logic pc_legal(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] depth = ADDR_W'(MEM_DEPTH));
    return (addr < depth) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory port, redirect request and decode handshake of the fetch stage.
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  // Fetch unit side.
  modport master (
    output imem_addr, out_valid, out_instr, out_pc,
    input  imem_data, branch_valid, branch_target, out_ready
  );

  // Memory / branch unit / decode side.
  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc,
    output imem_data, branch_valid, branch_target, out_ready
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a combinational instruction memory,
// and presents {instr, pc} to decode over valid/ready with redirect and fault handling.
module instruction_fetch
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W    = cpu_fetch_pkg::ADDR_W,
  parameter int unsigned DATA_W    = cpu_fetch_pkg::DATA_W,
  parameter int unsigned RESET_PC  = cpu_fetch_pkg::RESET_PC,
  parameter int unsigned MEM_DEPTH = cpu_fetch_pkg::MEM_DEPTH,
  parameter int unsigned PC_STEP   = cpu_fetch_pkg::PC_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  instruction_fetch_if.master    bus,
  output logic                   fault,
  output logic [31:0]            fetch_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic              fault_q, fault_d;
  logic [31:0]       fetch_count_q, fetch_count_d;

  logic transfer;
  logic slot_free;
  logic squash;
  logic pc_ok;
  logic target_ok;

  assign transfer  = out_valid_q && bus.out_ready;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign squash    = bus.branch_valid && (state_q != IDLE);
  assign pc_ok     = pc_legal(pc_q, ADDR_W'(MEM_DEPTH));
  assign target_ok = pc_legal(bus.branch_target, ADDR_W'(MEM_DEPTH));

  // Next-state, PC, output register and counter update; redirect beats fetch.
  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fault_d       = fault_q;
    fetch_count_d = fetch_count_q;

    // A completed handshake frees the slot; a squashed instruction is never counted.
    if (transfer) begin
      out_valid_d = 1'b0;
      if (!squash) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.branch_valid && target_ok) begin
          pc_d = bus.branch_target;
        end
        if (start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.branch_valid) begin
          out_valid_d = 1'b0;
          if (target_ok) begin
            pc_d = bus.branch_target;
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end else if (slot_free) begin
          if (pc_ok) begin
            out_instr_d = bus.imem_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(PC_STEP);
          end else begin
            fault_d = 1'b1;
            state_d = FAULT;
          end
        end
      end

      FAULT: begin
        if (bus.branch_valid) begin
          out_valid_d = 1'b0;
          if (target_ok) begin
            pc_d    = bus.branch_target;
            fault_d = 1'b0;
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with immediate asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= ADDR_W'(RESET_PC);
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fault_q       <= fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;
  assign fault         = fault_q;
  assign fetch_count   = fetch_count_q;

endmodule
